vblank_sched: RTL
=================

# vblank_sched

Per-frame update scheduler for the dinosaur game. It watches the vertical sync produced by the VGA timing block and, once per frame (or once every `FRAME_DIV` frames), sequences the game-logic requesters (ground, cactus, dinosaur, …) one at a time with a start/done handshake. All sprite-state updates therefore happen in vertical blanking, before active video resumes at line 35. It also keeps a free-running frame counter and reports overruns.

## Interface
- `N`, 3: number of requesters; index 0 is served first.
- `FRAME_DIV`, 1: issue a sequence every `FRAME_DIV` eligible frames (≥1).
- `TIMEOUT`, 20000: watchdog limit in `vga_clk` cycles per requester (below the 26400-cycle blanking window).

Ports:
- `vga_clk` in 1: 25 MHz pixel clock; the only clock.
- `clr` in 1: reset, asynchronous, active-high.
- `vs` in 1: registered vertical sync from the VGA timing block; low on lines 0–1, high otherwise.
- `pause` in 1: game paused or over; suppresses sequence issue.
- `done` in N: one-cycle completion pulse per requester.
- `start` out N: one-hot, one-cycle start pulse per requester.
- `busy` out 1: high while a sequence is in progress.
- `frame_done` out 1: one-cycle pulse when the last requester completes.
- `frame_cnt` out 16: count of vs rising edges, wraps.
- `missed` out 1: one-cycle pulse when a vs edge arrives while busy.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Edge detect: `vs_d` is registered from `vs`, with reset value 1. `edge = vs & ~vs_d`. Reset therefore never produces a false edge.
- `frame_cnt` increments on every edge, in any state and regardless of `pause`. It wraps 16'hFFFF→0.
- Divider `div_cnt` (0..`FRAME_DIV`−1):
  - A frame is eligible when `edge & ~pause & (state == IDLE)`.
  - On an eligible frame, a sequence issues iff `div_cnt == 0`.
  - `div_cnt` then advances and wraps to 0 after `FRAME_DIV`−1.
  - `div_cnt` holds while `pause` is high.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE → ISSUE on an issue condition; `idx` ← 0.
  - ISSUE: `start[idx]` = 1 for exactly this cycle; then → WAIT and the watchdog counter clears.
  - WAIT → ISSUE on `done[idx]`, with `idx` ← `idx`+1, if `idx` < N−1.
  - WAIT → IDLE on `done[idx]` if `idx` == N−1; `frame_done` pulses in the following cycle.
- `done` is sampled only in WAIT and only at bit `idx`. `done` on any other bit, or in any other state, is ignored. Requesters must answer no earlier than the cycle after `start`.
- `busy` = (state ≠ IDLE), registered with state.
- An edge while not IDLE:
  - `missed` pulses for one cycle.
  - The edge does not queue a sequence and does not advance `div_cnt`.
  - The current sequence continues.
- `pause` rising mid-sequence does not abort; the sequence completes.
- `clr` asserted at any time forces IDLE and every output to its reset value on the next evaluation. No `start` is emitted during reset.

## Timing
- Reset values:
  - `start` = 0, `busy` = 0, `frame_done` = 0, `missed` = 0, `timeout_err` = 0, `frame_cnt` = 0.
  - Internal: `div_cnt` = 0, `idx` = 0, `vs_d` = 1.
- Let cycle k be the first cycle `vs` is sampled high. Then:
  - `edge` is true in cycle k.
  - `frame_cnt` updates at the end of cycle k.
  - `start[0]` and `busy` are high in cycle k+1.
- If `done[i]` pulses in cycle m (WAIT), `start[i+1]` is high in cycle m+1.
- Minimum sequence length is 2N cycles: each requester answers one cycle after `start`.
- `frame_done` is a one-cycle pulse in the cycle after the final `done`, coincident with `busy` falling.
- `idx` is `$clog2(N)` bits wide. The watchdog counter is `$clog2(TIMEOUT+1)` bits wide and saturates.

## Configuration
- Macro: `VBLANK_SCHED_WATCHDOG_EN`.
- **Defined:**
  - In WAIT the watchdog counts cycles.
  - On reaching `TIMEOUT` without `done[idx]`, `timeout_err` sets and stays set until `clr`.
  - The FSM then advances exactly as if `done[idx]` had arrived, including `frame_done` on the last requester.
- **Undefined:**
  - No watchdog logic exists and WAIT waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Reset then idle: hold `vs` = 1 after reset release, 100 cycles → `start` = 0, `frame_cnt` = 0, `busy` = 0.
- Normal frame (N=3): vs falls, then rises in cycle k; each `done[i]` arrives 5 cycles after `start[i]` → `start` = 001 at k+1, then 010, then 100; `frame_done` 1 cycle after `done[2]`; `frame_cnt` = 1.
- Divider: `FRAME_DIV` = 3, 6 vs edges → sequences on edges 1 and 4 only; `frame_cnt` = 6. With `pause` = 1 over 2 edges → no `start`, `frame_cnt` +2, divider phase unchanged.
- Overrun: `done[1]` withheld across the next vs edge → `missed` pulses once, no restart; late `done[1]` resumes with `start[2]`.
- Watchdog (macro defined, `TIMEOUT` = 50): `done[0]` never arrives → `start[1]` 51 cycles after `start[0]`, `timeout_err` = 1 until `clr`. With macro undefined → `busy` stays 1 and `timeout_err` = 0.
- Async reset mid-WAIT: pulse `clr` between cycles → `busy`, `start`, and `frame_cnt` return to 0 immediately; no `start` until the next vs edge.

Source files
------------

// File: rtl/vblank_sched.sv
// Per-frame update scheduler: on a vs rising edge, runs each requester once via start/done.
// Define VBLANK_SCHED_WATCHDOG_EN to add the per-requester watchdog and timeout_err.
module vblank_sched #(
  parameter int N         = 3,
  parameter int FRAME_DIV = 1,
  parameter int TIMEOUT   = 20000
) (
  input  logic          vga_clk,
  input  logic          clr,
  input  logic          vs,
  input  logic          pause,
  input  logic [N-1:0]  done,
  output logic [N-1:0]  start,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic          missed,
  output logic          timeout_err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [IW-1:0] LAST     = IW'(N - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(FRAME_DIV - 1);

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic [DW-1:0] div_cnt;
  logic          vs_d, vs_edge, eligible, issue, advance;

  // vs_d resets high so a vs already high at reset release is not an edge
  assign vs_edge  = vs & ~vs_d;
  assign eligible = vs_edge & ~pause & (state == IDLE);
  assign issue    = eligible & (div_cnt == '0);
  assign busy     = (state != IDLE);

  always_comb begin
    start = '0;
    if (state == ISSUE) start = N'(1) << idx;
  end

`ifdef VBLANK_SCHED_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_fire;

  // Fires on the TIMEOUT-th WAIT cycle, so the next start lands TIMEOUT+1 after the previous
  assign wd_fire = (state == WAIT) && (wd_cnt == WW'(TIMEOUT - 1)) && !done[idx];
  assign advance = (state == WAIT) && (done[idx] || wd_fire);

  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != WAIT)               wd_cnt <= '0;
      else if (wd_cnt != WW'(TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_fire) timeout_err <= 1'b1;
    end
  end
`else
  assign advance     = (state == WAIT) && done[idx];
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      idx        <= '0;
      div_cnt    <= '0;
      vs_d       <= 1'b1;
      frame_cnt  <= '0;
      frame_done <= 1'b0;
      missed     <= 1'b0;
    end else begin
      vs_d       <= vs;
      frame_done <= 1'b0;
      missed     <= vs_edge & (state != IDLE);
      if (vs_edge)  frame_cnt <= frame_cnt + 16'd1;
      if (eligible) div_cnt   <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE:  if (issue) begin
                 state <= ISSUE;
                 idx   <= '0;
               end
        ISSUE: state <= WAIT;
        WAIT:  if (advance) begin
                 if (idx == LAST) begin
                   state      <= IDLE;
                   frame_done <= 1'b1;
                 end else begin
                   state <= ISSUE;
                   idx   <= idx + 1'b1;
                 end
               end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
